// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: plaintext/key intake and ciphertext output handshakes.
// master = block source and ciphertext sink, slave = sequencer.
interface aes_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_block, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_block, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 round sequencer in front of the
// state register; round function and key expansion live outside.
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   aes_round_ctrl_if.slave io,
   output logic          st_en,
   output logic [127:0]  st_d,
   input  logic [127:0]  st_q,
   output logic [127:0]  rk,
   output logic [7:0]    rcon,
   input  logic [127:0]  nk_in,
   input  logic [127:0]  rnd_in,
   output logic          last_round,
   output logic [RW-1:0] round,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [RW-1:0] LAST = RW'(NR);

   state_t state, state_nx;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and combinational handshake / state-register controls
   always_comb begin
      state_nx     = state;
      st_en        = 1'b0;
      st_d         = rnd_in;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      last_round   = 1'b0;
      unique case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            st_d        = io.in_block ^ io.in_key;
            if (io.in_valid) begin
               st_en    = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            st_en = 1'b1;
            if (round == LAST) begin
               last_round = 1'b1;
               state_nx   = DONE;
            end
         end
         DONE: begin
            io.out_valid = 1'b1;
            if (io.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // round key, Rcon and round counter advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk    <= '0;
         rcon  <= 8'h00;
         round <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io.in_valid) begin
                  rk    <= io.in_key;
                  rcon  <= 8'h01;
                  round <= RW'(1);
               end
            end
            RUN: begin
               rk <= nk_in;
               if (round == LAST) begin
                  rcon  <= 8'h01;
                  round <= '0;
               end else begin
                  rcon  <= xtime(rcon);
                  round <= round + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.out_data = st_q;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench with an AES-128 round/key model
// and the 128-bit state register around the sequencer.
module tb_aes_round_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          st_en;
   logic [127:0]  st_d;
   logic [127:0]  st_q;
   logic [127:0]  rk;
   logic [7:0]    rcon;
   logic [127:0]  nk_in;
   logic [127:0]  rnd_in;
   logic          last_round;
   logic [3:0]    round;
   logic          busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_round_ctrl_if io ();

   aes_round_ctrl #(.NR(10), .RW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (io.slave),
      .st_en      (st_en),
      .st_d       (st_d),
      .st_q       (st_q),
      .rk         (rk),
      .rcon       (rcon),
      .nk_in      (nk_in),
      .rnd_in     (rnd_in),
      .last_round (last_round),
      .round      (round),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // external state register sharing the reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     st_q <= '0;
      else if (st_en) st_q <= st_d;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] s = x;
      logic [7:0] b;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
             {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t  = t ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] st,
                                             input logic [127:0] k,
                                             input logic last);
      logic [7:0] sb [16];
      logic [7:0] sr [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[r+4*c] = sb[r + 4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
         if (!last) begin
            sr[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
            sr[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
            sr[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
            sr[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sr[i];
      return o ^ k;
   endfunction

   assign nk_in  = key_exp(rk, rcon);
   assign rnd_in = round_fn(st_q, nk_in, last_round);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      io.in_valid  = 1'b0;
      io.in_block  = '0;
      io.in_key    = '0;
      io.out_ready = 1'b0;
      #2;
      chk_cnt++;
      if (io.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", io.in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (io.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", io.out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
      else pass_cnt++;
      chk_cnt++;
      if (st_en !== 1'b0) $display("FAIL rst_st_en: got %b want 0", st_en);
      else pass_cnt++;
      chk_cnt++;
      if (rk !== 128'h0) $display("FAIL rst_rk: got %h want 0", rk);
      else pass_cnt++;
      chk_cnt++;
      if (round !== 4'd0) $display("FAIL rst_round: got %0d want 0", round);
      else pass_cnt++;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_cnt++;
      if (io.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", io.in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy);
      else pass_cnt++;
      chk_cnt++;
      if (rcon !== 8'h00) $display("FAIL post_rst_rcon: got %h want 00", rcon);
      else pass_cnt++;
      chk_cnt++;
      if (io.out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b want 0", io.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_c1();
      int n;
      io.in_valid = 1'b1;
      io.in_block = P1;
      io.in_key   = K1;
      #1;
      chk_cnt++;
      if (st_en !== 1'b1) $display("FAIL c1_accept_en: got %b want 1", st_en);
      else pass_cnt++;
      chk_cnt++;
      if (st_d !== (P1 ^ K1)) $display("FAIL c1_ark0: got %h want %h", st_d, P1 ^ K1);
      else pass_cnt++;
      step();
      io.in_valid = 1'b0;
      chk_cnt++;
      if (round !== 4'd1 || rk !== K1 || rcon !== 8'h01)
         $display("FAIL c1_e0_regs: got r=%0d rk=%h rc=%h want r=1 rk=%h rc=01",
                  round, rk, rcon, K1);
      else pass_cnt++;
      n = 0;
      while (!io.out_valid && n < 30) begin
         step();
         n++;
      end
      chk_cnt++;
      if (n !== 10) $display("FAIL c1_latency: got %0d want 10", n);
      else pass_cnt++;
      chk_cnt++;
      if (io.out_data !== C1) $display("FAIL c1_data: got %h want %h", io.out_data, C1);
      else pass_cnt++;
      io.out_ready = 1'b1;
      step();
      io.out_ready = 1'b0;
      chk_cnt++;
      if (io.in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL c1_to_idle: got rdy=%b busy=%b want rdy=1 busy=0", io.in_ready, busy);
      else pass_cnt++;
   endtask

   task automatic test_appb_rcon();
      logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      io.in_valid = 1'b1;
      io.in_block = P2;
      io.in_key   = K2;
      step();
      io.in_valid = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         chk_cnt++;
         if (round !== 4'(r)) $display("FAIL appb_round: got %0d want %0d", round, r);
         else pass_cnt++;
         chk_cnt++;
         if (rcon !== rc_tab[r-1]) $display("FAIL appb_rcon r%0d: got %h want %h", r, rcon, rc_tab[r-1]);
         else pass_cnt++;
         chk_cnt++;
         if (last_round !== (r == 10)) $display("FAIL appb_last r%0d: got %b want %b", r, last_round, r == 10);
         else pass_cnt++;
         step();
      end
      chk_cnt++;
      if (io.out_valid !== 1'b1 || io.out_data !== C2)
         $display("FAIL appb_data: got v=%b %h want v=1 %h", io.out_valid, io.out_data, C2);
      else pass_cnt++;
      chk_cnt++;
      if (last_round !== 1'b0 || round !== 4'd0 || rcon !== 8'h01)
         $display("FAIL appb_done_regs: got last=%b r=%0d rc=%h want 0 0 01", last_round, round, rcon);
      else pass_cnt++;
      io.out_ready = 1'b1;
      step();
      io.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      io.in_valid = 1'b1;
      io.in_block = P1;
      io.in_key   = K1;
      step();
      n = 0;
      while (!io.out_valid && n < 30) begin
         io.in_block = {4{$urandom()}};
         step();
         n++;
      end
      chk_cnt++;
      if (n !== 10) $display("FAIL bp_latency: got %0d want 10", n);
      else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         io.in_block = {4{$urandom()}};
         io.in_key   = {4{$urandom()}};
         #1;
         chk_cnt++;
         if (io.out_valid !== 1'b1 || io.out_data !== C1 || st_en !== 1'b0 || io.in_ready !== 1'b0)
            $display("FAIL bp_hold c%0d: got v=%b d=%h en=%b rdy=%b want 1 %h 0 0",
                     i, io.out_valid, io.out_data, st_en, io.in_ready, C1);
         else pass_cnt++;
         step();
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      step();
      io.out_ready = 1'b0;
      chk_cnt++;
      if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_release: got rdy=%b v=%b busy=%b want 1 0 0",
                  io.in_ready, io.out_valid, busy);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] pt  [3] = '{P1, P2, P1};
      logic [127:0] key [3] = '{K1, K2, K1};
      logic [127:0] ct  [3] = '{C1, C2, C1};
      int acc_t [3] = '{-100, -100, -100};
      int nacc = 0;
      int nout = 0;
      io.out_ready = 1'b1;
      for (int t = 0; t < 45; t++) begin
         if (io.out_valid) begin
            chk_cnt++;
            if (nout >= 3) $display("FAIL b2b_extra_out: got %0d outputs want 3", nout + 1);
            else if (io.out_data !== ct[nout])
               $display("FAIL b2b_data%0d: got %h want %h", nout, io.out_data, ct[nout]);
            else pass_cnt++;
            nout++;
         end
         if (io.in_ready) begin
            if (nacc < 3) begin
               io.in_valid = 1'b1;
               io.in_block = pt[nacc];
               io.in_key   = key[nacc];
               acc_t[nacc] = t;
               nacc++;
            end else begin
               io.in_valid = 1'b0;
            end
         end else begin
            io.in_valid = 1'b1;
            io.in_block = {4{$urandom()}};
            io.in_key   = {4{$urandom()}};
         end
         step();
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      chk_cnt++;
      if (nout !== 3) $display("FAIL b2b_count: got %0d want 3", nout);
      else pass_cnt++;
      chk_cnt++;
      if (acc_t[1] - acc_t[0] !== 12) $display("FAIL b2b_gap01: got %0d want 12", acc_t[1] - acc_t[0]);
      else pass_cnt++;
      chk_cnt++;
      if (acc_t[2] - acc_t[1] !== 12) $display("FAIL b2b_gap12: got %0d want 12", acc_t[2] - acc_t[1]);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      io.in_valid = 1'b1;
      io.in_block = P1;
      io.in_key   = K1;
      step();
      io.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk_cnt++;
      if (round !== 4'd5) $display("FAIL mr_round5: got %0d want 5", round);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (io.in_ready !== 1'b1 || busy !== 1'b0 || io.out_valid !== 1'b0)
         $display("FAIL mr_during: got rdy=%b busy=%b v=%b want 1 0 0", io.in_ready, busy, io.out_valid);
      else pass_cnt++;
      step();
      rst_n = 1'b1;
      step();
      chk_cnt++;
      if (round !== 4'd0 || rk !== 128'h0 || rcon !== 8'h00 || io.out_valid !== 1'b0)
         $display("FAIL mr_after: got r=%0d rk=%h rc=%h v=%b want 0 0 00 0",
                  round, rk, rcon, io.out_valid);
      else pass_cnt++;
      test_c1();
   endtask

   initial begin
      test_reset();
      test_c1();
      test_appb_rcon();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
